// File: rtl/sprite_color_quantizer.sv
// sprite_color_quantizer: maps an RGB444 pixel to the nearest entry of the
// fixed 16-entry sprite palette, testing one entry per clock.
module sprite_color_quantizer (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_rgb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_index,
    output logic [5:0]  out_dist,
    output logic        out_exact,
    output logic        out_transparent
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    state_t      state_q;
    logic [11:0] pixel_q;
    logic [3:0]  entry_q;
    logic [5:0]  bestDist_q;
    logic [3:0]  bestIdx_q;
    logic        inReady_q;
    logic        outValid_q;
    logic [3:0]  outIndex_q;
    logic [5:0]  outDist_q;
    logic        outExact_q;
    logic        outTransparent_q;

    logic [11:0] paletteColor;
    logic [3:0]  diffR;
    logic [3:0]  diffG;
    logic [3:0]  diffB;
    logic [5:0]  entryDist;
    logic [5:0]  bestDist_d;
    logic [3:0]  bestIdx_d;

    // Absolute difference of two 4-bit channel values.
    function automatic logic [3:0] absDiff(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Fixed palette ROM, entry 0 is the magenta transparency key.
    always_comb begin
        paletteColor = 12'hF0F;
        case (entry_q)
            4'd0:  paletteColor = 12'hF0F;
            4'd1:  paletteColor = 12'h915;
            4'd2:  paletteColor = 12'hD87;
            4'd3:  paletteColor = 12'h954;
            4'd4:  paletteColor = 12'h102;
            4'd5:  paletteColor = 12'hC1B;
            4'd6:  paletteColor = 12'hE9E;
            4'd7:  paletteColor = 12'h415;
            4'd8:  paletteColor = 12'h901;
            4'd9:  paletteColor = 12'h43A;
            4'd10: paletteColor = 12'hEB9;
            4'd11: paletteColor = 12'h733;
            4'd12: paletteColor = 12'hE1D;
            4'd13: paletteColor = 12'h521;
            4'd14: paletteColor = 12'hB76;
            4'd15: paletteColor = 12'hA18;
            default: paletteColor = 12'hF0F;
        endcase
    end

    // Manhattan distance to the current entry; strict compare keeps the lower index on ties.
    always_comb begin
        diffR     = absDiff(pixel_q[11:8], paletteColor[11:8]);
        diffG     = absDiff(pixel_q[7:4],  paletteColor[7:4]);
        diffB     = absDiff(pixel_q[3:0],  paletteColor[3:0]);
        entryDist = {2'b00, diffR} + {2'b00, diffG} + {2'b00, diffB};
        bestDist_d = bestDist_q;
        bestIdx_d  = bestIdx_q;
        if (entryDist < bestDist_q) begin
            bestDist_d = entryDist;
            bestIdx_d  = entry_q;
        end
    end

    // Control FSM with all handshake and result outputs registered.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q          <= IDLE;
            pixel_q          <= '0;
            entry_q          <= '0;
            bestDist_q       <= '0;
            bestIdx_q        <= '0;
            inReady_q        <= 1'b1;
            outValid_q       <= 1'b0;
            outIndex_q       <= '0;
            outDist_q        <= '0;
            outExact_q       <= 1'b0;
            outTransparent_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        pixel_q    <= in_rgb;
                        entry_q    <= '0;
                        bestDist_q <= 6'd63;
                        bestIdx_q  <= '0;
                        inReady_q  <= 1'b0;
                        state_q    <= SEARCH;
                    end
                end
                SEARCH: begin
                    bestDist_q <= bestDist_d;
                    bestIdx_q  <= bestIdx_d;
                    if ((entryDist == 6'd0) || (entry_q == 4'd15)) begin
                        outValid_q       <= 1'b1;
                        outIndex_q       <= bestIdx_d;
                        outDist_q        <= bestDist_d;
                        outExact_q       <= (bestDist_d == 6'd0);
                        outTransparent_q <= (bestIdx_d == 4'd0);
                        state_q          <= DONE;
                    end else begin
                        entry_q <= entry_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready        = inReady_q;
    assign out_valid       = outValid_q;
    assign out_index       = outIndex_q;
    assign out_dist        = outDist_q;
    assign out_exact       = outExact_q;
    assign out_transparent = outTransparent_q;

endmodule
